// File: rtl/jtag_tap_param.sv
// jtag_tap_param: parametrised IEEE 1149.1 test access port.
//
// Contains the 16-state TAP controller, an IR_WIDTH instruction register and the
// bypass, IDCODE, USERCODE, BIST-status and boundary-scan data registers, plus the
// pin muxing between the JTAG boundary cells and the core/pad signals.
//
// Ports:
//   TCK        test clock, the only clock
//   TRST       asynchronous active-low reset
//   TMS, TDI   sampled on posedge TCK
//   TDO        test data out, updated on negedge TCK
//   TDO_EN     high while in Shift-IR / Shift-DR (negedge registered)
//   pad_in     input pads           -> core_in   (to core)
//   core_out   core outputs         -> pad_out   (to pads)
//   pad_oe     pad output enable, dropped by HIGHZ
//   bist_run   BIST request, bist_done / bist_pass BIST handshake inputs
//   tap_state  current TAP controller state (debug)
//
// state | meaning
// F     | Test-Logic-Reset
// C     | Run-Test/Idle
// 7 / 4 | Select-DR-Scan / Select-IR-Scan
// 6 / E | Capture-DR / Capture-IR
// 2 / A | Shift-DR / Shift-IR
// 1 / 9 | Exit1-DR / Exit1-IR
// 3 / B | Pause-DR / Pause-IR
// 0 / 8 | Exit2-DR / Exit2-IR
// 5 / D | Update-DR / Update-IR
module jtag_tap_param #(
    parameter int          IR_WIDTH     = 4,
    parameter int          N_IN         = 2,
    parameter int          N_OUT        = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1234_5093,
    parameter logic [31:0] USERCODE_VAL = 32'h0000_0000,
    parameter int          OP_SAMPLE    = 1,
    parameter int          OP_EXTEST    = 2,
    parameter int          OP_INTEST    = 3,
    parameter int          OP_RUNBIST   = 4,
    parameter int          OP_CLAMP     = 5,
    parameter int          OP_IDCODE    = 7,
    parameter int          OP_USERCODE  = 8,
    parameter int          OP_HIGHZ     = 9
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    input  logic [N_IN-1:0]  pad_in,
    output logic [N_IN-1:0]  core_in,
    input  logic [N_OUT-1:0] core_out,
    output logic [N_OUT-1:0] pad_out,
    output logic             pad_oe,
    output logic             bist_run,
    input  logic             bist_done,
    input  logic             bist_pass,
    output logic [3:0]       tap_state
);

    localparam int N_BSR = N_IN + N_OUT;

    localparam logic [IR_WIDTH-1:0] op_sample   = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] op_extest   = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] op_intest   = IR_WIDTH'(OP_INTEST);
    localparam logic [IR_WIDTH-1:0] op_runbist  = IR_WIDTH'(OP_RUNBIST);
    localparam logic [IR_WIDTH-1:0] op_clamp    = IR_WIDTH'(OP_CLAMP);
    localparam logic [IR_WIDTH-1:0] op_idcode   = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] op_usercode = IR_WIDTH'(OP_USERCODE);
    localparam logic [IR_WIDTH-1:0] op_highz    = IR_WIDTH'(OP_HIGHZ);

    typedef enum logic [3:0] {
        ST_TLR    = 4'hF, ST_RTI    = 4'hC,
        ST_SELDR  = 4'h7, ST_CAPDR  = 4'h6, ST_SHDR  = 4'h2, ST_EX1DR = 4'h1,
        ST_PAUSDR = 4'h3, ST_EX2DR  = 4'h0, ST_UPDDR = 4'h5,
        ST_SELIR  = 4'h4, ST_CAPIR  = 4'hE, ST_SHIR  = 4'hA, ST_EX1IR = 4'h9,
        ST_PAUSIR = 4'hB, ST_EX2IR  = 4'h8, ST_UPDIR = 4'hD
    } tap_state_t;

    tap_state_t state, state_nxt;

    logic reset_st, capture_ir, shift_ir, update_ir;
    logic capture_dr, shift_dr, update_dr, in_rti;

    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass_sr;
    logic [31:0]         id_sr;
    logic [1:0]          bist_sr;
    logic [N_BSR-1:0]    bsr;
    logic [N_BSR-1:0]    bsr_latch;

    logic sel_bsr, sel_id, sel_uc, sel_runbist;
    logic is_sample, is_extest, is_intest, is_clamp, is_highz;
    logic dr_lsb;

    // ---------------- TAP controller ----------------
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state <= ST_TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_TLR:    state_nxt = TMS ? ST_TLR   : ST_RTI;
            ST_RTI:    state_nxt = TMS ? ST_SELDR : ST_RTI;
            ST_SELDR:  state_nxt = TMS ? ST_SELIR : ST_CAPDR;
            ST_CAPDR:  state_nxt = TMS ? ST_EX1DR : ST_SHDR;
            ST_SHDR:   state_nxt = TMS ? ST_EX1DR : ST_SHDR;
            ST_EX1DR:  state_nxt = TMS ? ST_UPDDR : ST_PAUSDR;
            ST_PAUSDR: state_nxt = TMS ? ST_EX2DR : ST_PAUSDR;
            ST_EX2DR:  state_nxt = TMS ? ST_UPDDR : ST_SHDR;
            ST_UPDDR:  state_nxt = TMS ? ST_SELDR : ST_RTI;
            ST_SELIR:  state_nxt = TMS ? ST_TLR   : ST_CAPIR;
            ST_CAPIR:  state_nxt = TMS ? ST_EX1IR : ST_SHIR;
            ST_SHIR:   state_nxt = TMS ? ST_EX1IR : ST_SHIR;
            ST_EX1IR:  state_nxt = TMS ? ST_UPDIR : ST_PAUSIR;
            ST_PAUSIR: state_nxt = TMS ? ST_EX2IR : ST_PAUSIR;
            ST_EX2IR:  state_nxt = TMS ? ST_UPDIR : ST_SHIR;
            ST_UPDIR:  state_nxt = TMS ? ST_SELDR : ST_RTI;
            default:   state_nxt = ST_TLR;
        endcase
    end

    always_comb begin
        reset_st   = (state == ST_TLR);
        in_rti     = (state == ST_RTI);
        capture_ir = (state == ST_CAPIR);
        shift_ir   = (state == ST_SHIR);
        update_ir  = (state == ST_UPDIR);
        capture_dr = (state == ST_CAPDR);
        shift_dr   = (state == ST_SHDR);
        update_dr  = (state == ST_UPDDR);
    end

    assign tap_state = state;

    // ---------------- instruction register ----------------
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)           ir_sr <= IR_WIDTH'(1);
        else if (capture_ir) ir_sr <= IR_WIDTH'(1);
        else if (shift_ir)   ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end

    // Active IR only moves at the Update-IR negedge, so the decode below is
    // stable for the whole of every other state.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST)          ir_q <= op_idcode;
        else if (reset_st)  ir_q <= op_idcode;
        else if (update_ir) ir_q <= ir_sr;
    end

    // Anything not listed selects the bypass register.
    always_comb begin
        sel_bsr     = 1'b0;
        sel_id      = 1'b0;
        sel_uc      = 1'b0;
        sel_runbist = 1'b0;
        is_sample   = 1'b0;
        is_extest   = 1'b0;
        is_intest   = 1'b0;
        is_clamp    = 1'b0;
        is_highz    = 1'b0;
        case (ir_q)
            op_sample:   begin sel_bsr = 1'b1; is_sample = 1'b1; end
            op_extest:   begin sel_bsr = 1'b1; is_extest = 1'b1; end
            op_intest:   begin sel_bsr = 1'b1; is_intest = 1'b1; end
            op_runbist:  sel_runbist = 1'b1;
            op_clamp:    is_clamp    = 1'b1;
            op_idcode:   sel_id      = 1'b1;
            op_usercode: sel_uc      = 1'b1;
            op_highz:    is_highz    = 1'b1;
            default:     ;
        endcase
    end

    // ---------------- data registers ----------------
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)           bypass_sr <= 1'b0;
        else if (capture_dr) bypass_sr <= 1'b0;
        else if (shift_dr)   bypass_sr <= TDI;
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            id_sr <= '0;
        end else if (sel_id || sel_uc) begin
            if (capture_dr)    id_sr <= sel_id ? IDCODE_VAL : USERCODE_VAL;
            else if (shift_dr) id_sr <= {TDI, id_sr[31:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bist_sr <= '0;
        end else if (sel_runbist) begin
            if (capture_dr)    bist_sr <= {bist_pass, bist_done};
            else if (shift_dr) bist_sr <= {TDI, bist_sr[1]};
        end
    end

    // INTEST captures the driven core inputs (the latch) rather than the pads.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bsr <= '0;
        end else if (sel_bsr) begin
            if (capture_dr)
                bsr <= {core_out, is_intest ? bsr_latch[N_IN-1:0] : pad_in};
            else if (shift_dr)
                bsr <= {TDI, bsr[N_BSR-1:1]};
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST)                     bsr_latch <= '0;
        else if (reset_st)             bsr_latch <= '0;
        else if (update_dr && sel_bsr) bsr_latch <= bsr;
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) bist_run <= 1'b0;
        else       bist_run <= in_rti && sel_runbist;
    end

    // ---------------- TDO ----------------
    always_comb begin
        if (sel_id || sel_uc)  dr_lsb = id_sr[0];
        else if (sel_runbist)  dr_lsb = bist_sr[0];
        else if (sel_bsr)      dr_lsb = bsr[0];
        else                   dr_lsb = bypass_sr;
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            TDO    <= shift_ir ? ir_sr[0] : (shift_dr ? dr_lsb : 1'b0);
            TDO_EN <= shift_ir || shift_dr;
        end
    end

    // ---------------- pin muxing ----------------
    assign pad_out = (is_extest || is_clamp) ? bsr_latch[N_BSR-1:N_IN] : core_out;
    assign core_in = is_intest ? bsr_latch[N_IN-1:0] : pad_in;
    assign pad_oe  = !is_highz;

endmodule
